// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular fetch-to-decode instruction buffer with multi-lane push/pop and flush
// Define IFQ_BYPASS_EN to forward pushes straight to the outputs while the queue is empty.
module inst_fetch_queue #(
   parameter int DEPTH  = 64,
   parameter int INST_W = 32,
   parameter int PUSH_N = 2,
   parameter int POP_N  = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [$clog2(PUSH_N+1)-1:0]   push_count,
   input  logic [PUSH_N*INST_W-1:0]      push_data,
   output logic                          push_ready,
   output logic [POP_N-1:0]              out_valid,
   output logic [POP_N*INST_W-1:0]       out_data,
   input  logic [$clog2(POP_N+1)-1:0]    pop_count,
   output logic [$clog2(DEPTH):0]        count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int LN = PUSH_N > POP_N ? PUSH_N : POP_N;
   logic [INST_W-1:0] mem_q [DEPTH];
   logic [INST_W-1:0] lane [LN];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] push_n, pop_req, pop_n, skip_n;
   logic bypass;
   for (genvar k = 0; k < LN; k++) begin : g_lane
      if (k < PUSH_N) begin : g_in
         assign lane[k] = push_data[(PUSH_N-1-k)*INST_W +: INST_W];
      end else begin : g_pad
         assign lane[k] = '0;
      end
   end
   assign push_ready = count_q <= CW'(DEPTH - PUSH_N);
   assign count = count_q;
   always_comb begin
      push_n  = !push_ready ? '0 : (CW'(push_count) > CW'(PUSH_N)) ? CW'(PUSH_N) : CW'(push_count);
      pop_req = (CW'(pop_count) > CW'(POP_N)) ? CW'(POP_N) : CW'(pop_count);
`ifdef IFQ_BYPASS_EN
      bypass  = !reset && !flush && count_q == '0 && push_n != '0;
      skip_n  = !bypass ? '0 : (pop_req < push_n) ? pop_req : push_n;
`else
      bypass  = 1'b0;
      skip_n  = '0;
`endif
      pop_n   = bypass ? '0 : (pop_req < count_q) ? pop_req : count_q;
      head_d  = head_q + AW'(pop_n);
      tail_d  = tail_q + AW'(push_n - skip_n);
      count_d = count_q + push_n - skip_n - pop_n;
   end
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   // lanes already consumed through the bypass are never stored
   always_ff @(posedge clk) begin
      if (!reset && !flush)
         for (int k = 0; k < PUSH_N; k++)
            if (CW'(k) >= skip_n && CW'(k) < push_n)
               mem_q[tail_q + AW'(CW'(k) - skip_n)] <= lane[k];
   end
   for (genvar i = 0; i < POP_N; i++) begin : g_slot
      logic [INST_W-1:0] src;
      assign src = bypass ? lane[i] : mem_q[head_q + AW'(i)];
      assign out_valid[i] = bypass ? CW'(i) < push_n : count_q > CW'(i);
      assign out_data[(POP_N-1-i)*INST_W +: INST_W] = out_valid[i] ? src : '0;
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed vector table, fill/wrap sequences and random traffic against a queue model
module tb_inst_fetch_queue;
   localparam int DEPTH = 64;
`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1, flush = 1'b0;
   logic [1:0] push_count = '0, pop_count = '0;
   logic [63:0] push_data = '0;
   logic push_ready;
   logic [1:0] out_valid;
   logic [63:0] out_data;
   logic [6:0] count;
   int total = 0, bad = 0;
   logic [31:0] mq [$];
   inst_fetch_queue #(.DEPTH(DEPTH), .INST_W(32), .PUSH_N(2), .POP_N(2)) dut (
      .clk(clk), .reset(reset), .flush(flush), .push_count(push_count),
      .push_data(push_data), .push_ready(push_ready), .out_valid(out_valid),
      .out_data(out_data), .pop_count(pop_count), .count(count)
   );
   always #5 clk = ~clk;
   typedef struct {
      bit rs, fl;
      int pc;
      logic [31:0] d0, d1;
      int pop, ecnt;
      logic [1:0] ev;
      logic [31:0] e0, e1;
   } vec_t;
   vec_t tv [15];
   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction
   function automatic int min2(int a, int b);
      return a < b ? a : b;
   endfunction
   task automatic step(input bit rs, input bit fl, input int pc, input logic [31:0] d0,
                       input logic [31:0] d1, input int popc);
      logic [31:0] ln [2];
      logic [31:0] ed [2];
      logic [1:0] ev;
      bit rdy, byp;
      int pn, skip, pe;
      ln[0] = d0;
      ln[1] = d1;
      @(negedge clk);
      reset = rs; flush = fl; push_count = 2'(pc); push_data = {d0, d1}; pop_count = 2'(popc);
      #1;
      rdy = mq.size() <= DEPTH - 2;
      byp = BYP && mq.size() == 0 && rdy && pc > 0 && !fl && !rs;
      for (int i = 0; i < 2; i++) begin
         ev[i] = byp ? (i < pc) : (i < mq.size());
         ed[i] = !ev[i] ? 32'h0 : byp ? ln[i] : mq[i];
      end
      chk("push_ready", 64'(push_ready), 64'(rdy));
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("slot0", 64'(out_data[63:32]), 64'(ed[0]));
      chk("slot1", 64'(out_data[31:0]), 64'(ed[1]));
      @(posedge clk);
      if (rs || fl) mq.delete();
      else begin
         pn = rdy ? pc : 0;
         skip = byp ? min2(popc, pn) : 0;
         pe = byp ? 0 : min2(popc, mq.size());
         repeat (pe) void'(mq.pop_front());
         for (int k = skip; k < pn; k++) mq.push_back(ln[k]);
      end
   endtask
   initial begin
      tv[0]  = '{1'b1, 1'b0, 0, 32'h0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0};
      tv[1]  = '{1'b0, 1'b0, 2, 32'h11111111, 32'h22222222, 0, 2, 2'b11, 32'h11111111, 32'h22222222};
      tv[2]  = '{1'b0, 1'b0, 1, 32'h33333333, 32'h44444444, 1, 2, 2'b11, 32'h22222222, 32'h33333333};
      tv[3]  = '{1'b0, 1'b0, 1, 32'h44444444, 32'h0, 0, 3, 2'b11, 32'h22222222, 32'h33333333};
      tv[4]  = '{1'b0, 1'b0, 1, 32'h55555555, 32'h0, 1, 3, 2'b11, 32'h33333333, 32'h44444444};
      tv[5]  = '{1'b0, 1'b0, 0, 32'h0, 32'h0, 2, 1, 2'b01, 32'h55555555, 32'h0};
      tv[6]  = '{1'b0, 1'b0, 0, 32'h0, 32'h0, 2, 0, 2'b00, 32'h0, 32'h0};
      tv[7]  = '{1'b0, 1'b0, 2, 32'hA0000000, 32'hA0000001, 0, 2, 2'b11, 32'hA0000000, 32'hA0000001};
      tv[8]  = '{1'b0, 1'b0, 2, 32'hA0000002, 32'hA0000003, 0, 4, 2'b11, 32'hA0000000, 32'hA0000001};
      tv[9]  = '{1'b0, 1'b0, 2, 32'hA0000004, 32'hA0000005, 0, 6, 2'b11, 32'hA0000000, 32'hA0000001};
      tv[10] = '{1'b0, 1'b0, 2, 32'hA0000006, 32'hA0000007, 0, 8, 2'b11, 32'hA0000000, 32'hA0000001};
      tv[11] = '{1'b0, 1'b0, 2, 32'hA0000008, 32'hA0000009, 0, 10, 2'b11, 32'hA0000000, 32'hA0000001};
      tv[12] = '{1'b0, 1'b1, 2, 32'hDEADBEEF, 32'hCAFEF00D, 0, 0, 2'b00, 32'h0, 32'h0};
      tv[13] = '{1'b0, 1'b0, 2, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 2, 2'b11, 32'hAAAAAAAA, 32'hBBBBBBBB};
      tv[14] = '{1'b1, 1'b0, 2, 32'hCCCCCCCC, 32'hDDDDDDDD, 1, 0, 2'b00, 32'h0, 32'h0};
      repeat (2) @(posedge clk);
      #1;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_ready", 64'(push_ready), 64'd1);
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_data", out_data, 64'd0);
      foreach (tv[v]) begin
         step(tv[v].rs, tv[v].fl, tv[v].pc, tv[v].d0, tv[v].d1, tv[v].pop);
         #1;
         chk($sformatf("vec%0d_count", v), 64'(count), 64'(tv[v].ecnt));
         chk($sformatf("vec%0d_valid", v), 64'(out_valid), 64'(tv[v].ev));
         chk($sformatf("vec%0d_slot0", v), 64'(out_data[63:32]), 64'(tv[v].e0));
         chk($sformatf("vec%0d_slot1", v), 64'(out_data[31:0]), 64'(tv[v].e1));
      end
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) step(0, 0, 2, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i), 0);
      #1;
      chk("full_count", 64'(count), 64'd64);
      chk("full_ready", 64'(push_ready), 64'd0);
      step(0, 0, 2, 32'hBAD0BAD0, 32'hBAD1BAD1, 0);
      #1;
      chk("full_push_ignored", 64'(count), 64'd64);
      step(0, 0, 0, 0, 0, 1);
      #1;
      chk("pop1_count", 64'(count), 64'd63);
      chk("pop1_ready", 64'(push_ready), 64'd0);
      step(0, 0, 0, 0, 0, 1);
      #1;
      chk("pop2_count", 64'(count), 64'd62);
      chk("pop2_ready", 64'(push_ready), 64'd1);
      for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 0, 2);
      for (int i = 0; i < 4; i++) step(0, 0, 2, 32'h200 + 32'(2*i), 32'h201 + 32'(2*i), 0);
      #1;
      chk("wrap_count", 64'(count), 64'd10);
      chk("wrap_head", 64'(out_data[63:32]), 64'h13E);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 2);
      #1;
      chk("wrap_drained", 64'(count), 64'd0);
`ifdef IFQ_BYPASS_EN
      step(0, 0, 2, 32'hAAAAAAAA, 32'hBBBBBBBB, 1);
      #1;
      chk("byp_count", 64'(count), 64'd1);
      chk("byp_slot0", 64'(out_data[63:32]), 64'hBBBBBBBB);
`endif
      for (int c = 0; c < 3000; c++) begin
         int pc, popc;
         pc = int'($urandom_range(0, 2));
         popc = ((c / 250) % 2 == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
         step($urandom_range(0, 399) == 0, $urandom_range(0, 149) == 0, pc, $urandom, $urandom, popc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Parametrised circular instruction buffer between fetch and decode in the multi-issue pipeline. Accepts up to PUSH_N instructions per cycle from the fetch path and presents the oldest POP_N entries to decode, which retires 0..POP_N of them per cycle. Adds exact full/empty tracking, partial push and pop, and a flush for redirects.

Parameters:
DEPTH, 64, entry count; power of two, at least 2*max(PUSH_N,POP_N)
INST_W, 32, bits per instruction
PUSH_N, 2, maximum instructions enqueued per cycle
POP_N, 2, maximum instructions dequeued per cycle

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  discard all entries (branch redirect)
push_count  in  clog2(PUSH_N+1)  number of valid lanes in push_data, taken from lane 0 upward
push_data  in  PUSH_N*INST_W  lane 0 in the leftmost (most-significant) INST_W bits; lane 0 is the oldest instruction
push_ready  out  1  free entries >= PUSH_N
out_valid  out  POP_N  bit i set when slot i holds a valid entry
out_data  out  POP_N*INST_W  slot 0 (leftmost) is the oldest (head) entry
pop_count  in  clog2(POP_N+1)  number of slots consumed this cycle
count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. On a reset edge head=0, tail=0, count=0. Afterwards push_ready=1, out_valid=0, out_data=0. Storage contents are don't-care.
- Pointers: head and tail are clog2(DEPTH) bits wide and wrap modulo DEPTH with no special-casing. count is tracked explicitly, so full (count==DEPTH) and empty (count==0) are unambiguous.
- Push: accepted on an edge when push_ready=1. Lane k (k < push_count) is written to tail+k mod DEPTH, then tail advances by push_count.
- push_ready is computed from the current count only. Pops in the same cycle are not credited, so the free-space check stays conservative and push_ready has no combinational path from pop_count.
- A push with push_ready=0 is ignored. State is unchanged and no error is flagged. push_count=0 is a no-op.
- Outputs: out_valid[i] = (count > i). out_data slot i = mem[head+i mod DEPTH] when valid, else 0.
- Outputs are combinational from registered state. Read latency is 1 cycle: an entry pushed at edge N is visible after edge N.
- Pop: effective pop = min(pop_count, count). head advances by the effective pop; over-requests are clamped silently. The new count is count + accepted push - effective pop.
- Simultaneous push and pop at full: pop proceeds, push is refused (push_ready=0).
- Simultaneous push and pop at empty: push proceeds, pop is clamped to 0 unless IFQ_BYPASS_EN is defined.
- flush has priority over push and pop. On a flush edge head=tail=0 and count=0, and any push that cycle is discarded. Flush has the same architectural effect as reset.
- Reset has priority over flush. Reset mid-stream discards all entries.
- Width rule: all pointer arithmetic is truncated to clog2(DEPTH) bits; count never exceeds DEPTH.

Optional Feature:
IFQ_BYPASS_EN.
- Defined: when count==0 and push is accepted, lanes 0..push_count-1 drive out_valid/out_data combinationally in the same cycle.
- Under bypass, pop_count may consume bypassed lanes. Consumed lanes are not written; the rest are enqueued starting at tail, and tail advances by push_count minus bypass-popped.
- flush still discards everything.
- Undefined: no push-to-output path; minimum latency is 1 cycle.

Test Plan:
- Reset, then push 0x11111111/0x22222222 (push_count=2), pop_count=0 → next cycle count=2, out_valid=2'b11, slot0=0x11111111, slot1=0x22222222.
- DEPTH=64: push 2/cycle for 32 cycles with no pops → count=64, push_ready=0. A 33rd push is ignored. Pop 1 → count=63; push_ready stays 0 until count<=62.
- Wrap-around: fill to 64, pop 2/cycle for 31 cycles, push 8 more → order is preserved across the index 63→0 boundary; data pops out in strict FIFO order.
- count=1, pop_count=2 → effective pop 1, count=0, head advances by 1.
- push_count=1 with pop_count=1 from count=3 → count stays 3; slot0 becomes the old entry 1.
- flush asserted together with push_count=2 at count=10 → count=0, out_valid=0.
- IFQ_BYPASS_EN defined: push 0xAAAAAAAA/0xBBBBBBBB at empty with pop_count=1 → same cycle out_data slot0=0xAAAAAAAA; next cycle count=1, slot0=0xBBBBBBBB.
